// File: rtl/dsd_pkg.sv
// Shared definitions for the team's small arithmetic blocks:
// the serial-adder FSM state encoding and a counter-width helper.
package dsd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, purely combinational; reused by several arithmetic blocks.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: one full-adder slice and a carry flop reused
// over WIDTH cycles; the result is published on a one-cycle done pulse.
module serial_adder
    import dsd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_s;
    logic fa_cout;
    logic accept;

    full_adder u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_cout)
    );

    // New operands are taken in IDLE and in DONE, never while bits are in flight.
    assign accept = start && (state_q != RUN);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            RUN: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = fa_cout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, so an aborted addition leaves nothing behind.
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values of the others.
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of serial_adder at WIDTH=4 plus a random sweep at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    int checks;
    int failures;

    serial_adder #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start4),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .busy (busy4),
        .done (done4),
        .sum  (sum4),
        .cout (cout4)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .busy (busy8),
        .done (done8),
        .sum  (sum8),
        .cout (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete WIDTH=4 addition started from IDLE.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                        input logic [3:0] exp_sum, input logic exp_cout, input string tag);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = 4'hA; b4 = 4'h5; cin4 = 1'b1;
        check({tag, "_busy0"}, busy4, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check({tag, "_busy_run"}, {busy4, done4}, 2'b10);
        end
        tick();
        check({tag, "_done"}, {busy4, done4}, 2'b01);
        check({tag, "_sum"}, sum4, exp_sum);
        check({tag, "_cout"}, cout4, exp_cout);
        tick();
        check({tag, "_after"}, {busy4, done4}, 2'b00);
        check({tag, "_hold"}, {cout4, sum4}, {exp_cout, exp_sum});
    endtask

    logic [7:0] prev_sum8;
    logic       prev_cout8;
    logic [8:0] model8;
    bit         got_done;

    initial begin
        checks   = 0;
        failures = 0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

        // Asynchronous reset before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_async", {busy4, done4, cout4, sum4}, 7'd0);
        check("reset_async8", {busy8, done8, cout8, sum8}, 11'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_idle", {busy4, done4, cout4, sum4}, 7'd0);

        run4(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, "add5_3");

        // Second start pulse during RUN must be ignored.
        a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ign_busy", busy4, 1'b1);
        check("ign_sum_stable", sum4, 4'd8);
        tick();
        tick();
        check("ign_done", {busy4, done4, sum4}, {2'b01, 4'd4});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ign_no_second", {busy4, done4}, 2'b00);
        end

        // Start held high: back-to-back results every WIDTH+1 cycles.
        a4 = 4'd1; b4 = 4'd1; cin4 = 1'b0; start4 = 1'b1;
        tick();
        a4 = 4'd6; b4 = 4'd6;
        for (int i = 0; i < 4; i++) begin
            check("b2b_busy1", {busy4, done4}, 2'b10);
            tick();
        end
        check("b2b_done1", {busy4, done4, cout4, sum4}, {2'b01, 1'b0, 4'd2});
        tick();
        a4 = 4'd0; b4 = 4'd0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_busy2", {busy4, done4, sum4}, {2'b10, 4'd2});
            tick();
        end
        check("b2b_done2", {busy4, done4, cout4, sum4}, {2'b01, 1'b0, 4'd12});
        start4 = 1'b0;
        tick();
        check("b2b_idle", {busy4, done4}, 2'b00);

        run4(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, "add15_1");
        run4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, "add15_15_1");

        // Reset mid-RUN, between edges.
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("midrst_pre", {busy4, cout4, sum4}, {1'b1, 1'b1, 4'd15});
        #2 rst_n = 1'b0;
        #1;
        check("midrst_now", {busy4, done4, cout4, sum4}, 7'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_hold", {busy4, done4, cout4, sum4}, 7'd0);
        end
        rst_n = 1'b1;
        tick();
        check("midrst_release", {busy4, done4}, 2'b00);
        run4(4'd9, 4'd4, 1'b0, 4'd13, 1'b0, "add9_4");

        // WIDTH=8 random sweep with stability of sum/cout between results.
        prev_sum8  = sum8;
        prev_cout8 = cout8;
        check("w8_initial", {cout8, sum8}, 9'd0);
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            model8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            got_done = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (done8) begin
                    got_done = 1'b1;
                    break;
                end
                check("w8_stable", {cout8, sum8}, {prev_cout8, prev_sum8});
                tick();
            end
            check("w8_done_seen", got_done, 1'b1);
            check("w8_result", {cout8, sum8}, model8);
            prev_sum8  = model8[7:0];
            prev_cout8 = model8[8];
            tick();
            check("w8_done_pulse", done8, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
